// File: rtl/cache_req_gen.sv
// Directed request initiator for the CPU-side port of the L1 cache: queues commands,
// issues them one at a time, checks read data and keeps hit/miss/error/timeout statistics.
module cache_req_gen #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [3:0]       cmd_be,
  input  logic [31:0]      cmd_wd,
  output logic [31:0]      a,
  output logic [3:0]       be,
  output logic             read,
  output logic             write,
  output logic [31:0]      wd,
  input  logic [31:0]      rd,
  input  logic             rd_valid,
  input  logic             req_hit,
  input  logic             req_miss,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic [31:0]      err_data,
  output logic             timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [PW:0]   FULL      = (PW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] OP_GAP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_CHK = 2'b11;

  typedef enum logic [2:0] {IDLE, REQ, GAP, WAITN, HALT} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- command FIFO
  logic [1:0]  f_op [DEPTH];
  logic [31:0] f_a  [DEPTH];
  logic [3:0]  f_be [DEPTH];
  logic [31:0] f_wd [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  assign push = cmd_valid && cmd_ready;
  assign pop  = (state == IDLE) && (count != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the block order never changes behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after the count
  // says it was written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wr_ptr] <= cmd_op;
      f_a[wr_ptr]  <= cmd_a;
      f_be[wr_ptr] <= cmd_be;
      f_wd[wr_ptr] <= cmd_wd;
    end
  end

  logic [1:0]  h_op;
  logic [31:0] h_a, h_wd;
  logic [3:0]  h_be;

  assign h_op = f_op[rd_ptr];
  assign h_a  = f_a[rd_ptr];
  assign h_be = f_be[rd_ptr];
  assign h_wd = f_wd[rd_ptr];

  // ---------------------------------------------------------------- request datapath
  logic [1:0]    op_r;
  logic [WW-1:0] wait_cnt;
  logic [8:0]    gap_cnt;
  logic          miss_seen;
  logic          req_done, timed_out, mismatch;
  logic [31:0]   be_mask;

  assign req_done  = (op_r == OP_WR) ? req_hit : rd_valid;
  assign timed_out = (wait_cnt == WAIT_LAST);
  assign be_mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign mismatch  = |((rd ^ wd) & be_mask);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = (h_op == OP_GAP) ? WAITN : REQ;
      REQ:     if (req_done) state_nxt = GAP;
               else if (timed_out) state_nxt = HALT;
      GAP:     state_nxt = IDLE;
      WAITN:   if (gap_cnt == 9'd1) state_nxt = IDLE;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes come straight from the state, so leaving REQ (or reset) drops them at that edge.
  always_comb begin
    read      = (state == REQ) && (op_r != OP_WR);
    write     = (state == REQ) && (op_r == OP_WR);
    busy      = (count != '0) || (state != IDLE);
    cmd_ready = (count != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a         <= '0;
      be        <= '0;
      wd        <= '0;
      op_r      <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      miss_seen <= 1'b0;
      done_cnt  <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_data  <= '0;
      timeout   <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (h_op == OP_GAP) begin
              gap_cnt <= {1'b0, h_a[7:0]} + 9'd1;
            end else begin
              a         <= h_a;
              be        <= h_be;
              wd        <= h_wd;
              op_r      <= h_op;
              wait_cnt  <= '0;
              miss_seen <= 1'b0;
            end
          end
        end
        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (req_miss) miss_seen <= 1'b1;
          if (req_done) begin
            done_cnt <= sat_inc(done_cnt);
            // A miss flagged on the completion cycle itself still counts as a miss.
            if (miss_seen || req_miss) miss_cnt <= sat_inc(miss_cnt);
            else                       hit_cnt  <= sat_inc(hit_cnt);
            if ((op_r == OP_CHK) && mismatch) begin
              err_cnt   <= sat_inc(err_cnt);
              err_valid <= 1'b1;
              err_addr  <= a;
              err_data  <= rd;
            end
          end else if (timed_out) begin
            timeout <= 1'b1;
          end
        end
        WAITN:   gap_cnt <= gap_cnt - 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_gen.sv
// Directed bench for cache_req_gen: a small cache responder drives rd/rd_valid/req_hit/req_miss,
// a monitor measures strobe pulses and gaps, and the main sequence checks hand-computed values.
module tb_cache_req_gen;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [3:0]       cmd_be;
  logic [31:0]      cmd_wd;
  logic [31:0]      a;
  logic [3:0]       be;
  logic             read;
  logic             write;
  logic [31:0]      wd;
  logic [31:0]      rd;
  logic             rd_valid;
  logic             req_hit;
  logic             req_miss;
  logic             busy;
  logic [CNT_W-1:0] done_cnt, hit_cnt, miss_cnt, err_cnt;
  logic             err_valid;
  logic [31:0]      err_addr, err_data;
  logic             timeout;

  cache_req_gen #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_be(cmd_be), .cmd_wd(cmd_wd),
    .a(a), .be(be), .read(read), .write(write), .wd(wd),
    .rd(rd), .rd_valid(rd_valid), .req_hit(req_hit), .req_miss(req_miss),
    .busy(busy), .done_cnt(done_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .err_cnt(err_cnt), .err_valid(err_valid), .err_addr(err_addr), .err_data(err_data),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Responder configuration, written by the main sequence only.
  int          lat          = 2;
  bit          stall        = 1'b0;
  bit          miss_mode    = 1'b0;
  bit          rd_force     = 1'b0;
  logic [31:0] rd_force_val = '0;

  // Cache responder: answers on the cycle the strobe has been high 'lat' cycles.
  logic [31:0] mem [256];
  initial begin
    int age;
    age = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rd = '0; rd_valid = 1'b0; req_hit = 1'b0; req_miss = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !(read || write)) begin
        age = 0;
        rd = '0; rd_valid = 1'b0; req_hit = 1'b0; req_miss = 1'b0;
      end else begin
        age++;
        req_miss = miss_mode && (age <= 2);
        rd_valid = 1'b0;
        req_hit  = 1'b0;
        if (!stall && write) begin
          req_hit = (age == lat);
          if (age == lat)
            for (int b = 0; b < 4; b++)
              if (be[b]) mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end else if (!stall) begin
          rd_valid = (age == lat);
          rd       = rd_force ? rd_force_val : mem[a[9:2]];
        end
      end
    end
  end

  // Monitor: strobe pulse lengths, low gaps between pulses, address log, err pulses.
  int          pulse_len, last_len, low_run, last_gap, min_gap, err_pulses, log_n;
  bit          both_high, a_moved, seen_pulse, prev_strobe;
  logic [31:0] pulse_a;
  logic [31:0] req_log [32];
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pulse_len = 0; last_len = 0; low_run = 0; last_gap = 0; min_gap = 999;
        err_pulses = 0; log_n = 0; both_high = 0; a_moved = 0; seen_pulse = 0;
        prev_strobe = 0; pulse_a = '0;
      end else begin
        if (read && write) both_high = 1;
        if (err_valid) err_pulses++;
        if ((read || write) && !prev_strobe) begin
          if (seen_pulse) begin
            last_gap = low_run;
            if (low_run < min_gap) min_gap = low_run;
          end
          if (log_n < 32) req_log[log_n] = a;
          log_n++;
          pulse_len = 0;
          pulse_a   = a;
        end
        if (read || write) begin
          pulse_len++;
          last_len   = pulse_len;
          seen_pulse = 1;
          low_run    = 0;
          if (a !== pulse_a) a_moved = 1;
        end else begin
          low_run++;
        end
        prev_strobe = read || write;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [3:0] bmask,
                      input logic [31:0] data, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = addr; cmd_be = bmask; cmd_wd = data;
    acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    bit ok;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_be = '0; cmd_wd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_a_be_wd", a | wd | 32'(be), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_counters", 32'(done_cnt | hit_cnt | miss_cnt | err_cnt), 32'd0);
    check("rst_err", err_addr | err_data | 32'(err_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Write then read-and-check the same word, both answered as hits
    lat = 2;
    push(2'b10, 32'h100, 4'hF, 32'hDEADBEEF, acc);
    push(2'b11, 32'h100, 4'hF, 32'hDEADBEEF, acc);
    wait_idle(100, "wc_idle");
    check("wc_done", 32'(done_cnt), 32'd2);
    check("wc_hit", 32'(hit_cnt), 32'd2);
    check("wc_err", 32'(err_cnt), 32'd0);
    check("wc_both_high", 32'(both_high), 32'd0);
    check("wc_min_gap_ge1", 32'(min_gap >= 1), 32'd1);

    // Masked compare: upper bytes differ but are not enabled, then fully enabled
    do_reset();
    rd_force = 1'b1; rd_force_val = 32'hFFFF1234;
    push(2'b11, 32'h104, 4'h3, 32'h00001234, acc);
    wait_idle(100, "mm_idle1");
    check("mm_masked_err", 32'(err_cnt), 32'd0);
    check("mm_masked_pulse", 32'(err_pulses), 32'd0);
    push(2'b11, 32'h104, 4'hF, 32'h00001234, acc);
    wait_idle(100, "mm_idle2");
    check("mm_err_cnt", 32'(err_cnt), 32'd1);
    check("mm_err_pulses", 32'(err_pulses), 32'd1);
    check("mm_err_addr", err_addr, 32'h104);
    check("mm_err_data", err_data, 32'hFFFF1234);
    check("mm_done", 32'(done_cnt), 32'd2);
    rd_force = 1'b0;

    // Miss then fill: req_miss on cycles 1-2, rd_valid on cycle 7
    do_reset();
    lat = 7; miss_mode = 1'b1;
    push(2'b01, 32'h300, 4'hF, 32'h0, acc);
    wait_idle(100, "mf_idle");
    check("mf_miss", 32'(miss_cnt), 32'd1);
    check("mf_hit", 32'(hit_cnt), 32'd0);
    check("mf_done", 32'(done_cnt), 32'd1);
    check("mf_read_len", 32'(last_len), 32'd7);
    check("mf_a_stable", 32'(a_moved), 32'd0);
    miss_mode = 1'b0; lat = 2;

    // Idle gap of 4 between two reads: GAP + IDLE + 5 WAITN + IDLE = 8 low cycles
    do_reset();
    push(2'b01, 32'h10, 4'hF, 32'h0, acc);
    push(2'b00, 32'h04, 4'h0, 32'h0, acc);
    push(2'b01, 32'h14, 4'hF, 32'h0, acc);
    wait_idle(100, "ig_idle");
    check("ig_low_gap", 32'(last_gap), 32'd8);
    check("ig_done", 32'(done_cnt), 32'd2);

    // Full FIFO: stall the engine in a 256-cycle gap, then push 17 reads
    do_reset();
    push(2'b00, 32'hFF, 4'h0, 32'h0, acc);
    repeat (2) @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(2'b01, 32'h200 + 32'(4 * i), 4'hF, 32'h0, acc);
      if (!acc) ok = 1'b0;
    end
    check("ff_16_accepted", 32'(ok), 32'd1);
    check("ff_ready_full", 32'(cmd_ready), 32'd0);
    push(2'b01, 32'h2FC, 4'hF, 32'h0, acc);
    check("ff_17th_rejected", 32'(acc), 32'd0);
    wait_idle(1000, "ff_idle");
    check("ff_done", 32'(done_cnt), 32'd16);
    check("ff_req_count", 32'(log_n), 32'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("ff_order_%0d", i), req_log[i], 32'h200 + 32'(4 * i));

    // Timeout: no response ever, then HALT until reset
    do_reset();
    stall = 1'b1;
    push(2'b01, 32'h40, 4'hF, 32'h0, acc);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout) begin ok = 1'b1; break; end
    end
    check("to_seen", 32'(ok), 32'd1);
    check("to_read_len", 32'(last_len), 32'd8);
    check("to_read_low", 32'(read), 32'd0);
    check("to_done", 32'(done_cnt), 32'd0);
    push(2'b01, 32'h44, 4'hF, 32'h0, acc);
    check("to_halt_accepts", 32'(acc), 32'd1);
    repeat (5) @(negedge clk);
    check("to_halt_no_issue", 32'(log_n), 32'd1);
    check("to_halt_busy", 32'(busy), 32'd1);
    do_reset();
    check("to_rst_timeout", 32'(timeout), 32'd0);
    check("to_rst_busy", 32'(busy), 32'd0);
    check("to_rst_strobes", {30'd0, read, write}, 32'd0);
    stall = 1'b0;
    push(2'b01, 32'h48, 4'hF, 32'h0, acc);
    wait_idle(100, "to_resume_idle");
    check("to_resume_done", 32'(done_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
